// File: rtl/bls_data_server.sv
// Option-record server: fetches DATASIZE-bit records from word memory into
// per-module registers, arbitrating round-robin among modules asking for data.
module bls_data_server #(
  parameter int BSMODS   = 1,
  parameter int DATASIZE = 192,
  parameter int WORDW    = 32,
  parameter int AW       = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         startSystem,
  input  logic [AW-1:0]                numRecords,
  input  logic [AW-1:0]                baseAddr,
  input  logic [BSMODS-1:0]            SERVE_REG,
  input  logic [BSMODS-1:0]            BS_START,
  output logic                         mem_rd_en,
  output logic [AW-1:0]                mem_addr,
  input  logic [WORDW-1:0]             mem_rdata,
  output logic [BSMODS*DATASIZE-1:0]   BS_DATA,
  output logic [BSMODS-1:0]            REG_READY,
  output logic [BSMODS-1:0]            hasUnusedData,
  output logic                         OutOfData,
  output logic [AW-1:0]                recordsServed
);

  localparam int WORDS = DATASIZE / WORDW;
  localparam int GW    = (BSMODS > 1) ? $clog2(BSMODS) : 1;
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_FETCH, S_CAPTURE, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [GW-1:0]                grant_q, grant_d;
  logic [GW-1:0]                rr_q, rr_d;
  logic [KW-1:0]                cnt_q, cnt_d;
  logic [AW-1:0]                base_q, base_d;
  logic [AW-1:0]                num_q, num_d;
  logic [AW-1:0]                served_q, served_d;
  logic [BSMODS-1:0]            unused_q, unused_d;
  logic [BSMODS*DATASIZE-1:0]   data_q, data_d;
  logic                         pend_q, pend_d;
  logic [KW-1:0]                pidx_q, pidx_d;

  logic [BSMODS-1:0]            elig;
  logic                         found;
  logic [GW-1:0]                pick;
  logic [AW-1:0]                served_inc;
  logic                         filling;

  assign elig       = SERVE_REG & ~unused_q;
  assign served_inc = served_q + 1'b1;
  assign filling    = (state_q == S_FETCH) || (state_q == S_CAPTURE);

  // Round-robin: first eligible index at or above the pointer, else the lowest.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int j = 0; j < BSMODS; j++) begin
      if (!found && elig[j] && (j >= int'(rr_q))) begin
        found = 1'b1;
        pick  = GW'(j);
      end
    end
    for (int j = 0; j < BSMODS; j++) begin
      if (!found && elig[j]) begin
        found = 1'b1;
        pick  = GW'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    num_d    = num_q;
    served_d = served_q;
    unused_d = unused_q & ~BS_START;
    data_d   = data_q;
    pend_d   = 1'b0;
    pidx_d   = pidx_q;

    // Read data arrives one cycle after its strobe; land it in the granted slot.
    if (pend_q) begin
      for (int j = 0; j < BSMODS; j++) begin
        for (int k = 0; k < WORDS; k++) begin
          if ((GW'(j) == grant_q) && (KW'(k) == pidx_q))
            data_d[j*DATASIZE + k*WORDW +: WORDW] = mem_rdata;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (startSystem) begin
          base_d  = baseAddr;
          num_d   = numRecords;
          state_d = (numRecords == '0) ? S_DONE : S_ARB;
        end
      end
      S_ARB: begin
        if (found) begin
          grant_d = pick;
          rr_d    = (pick == GW'(BSMODS-1)) ? '0 : pick + 1'b1;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        pend_d = 1'b1;
        pidx_d = cnt_q;
        if (cnt_q == KW'(WORDS-1)) begin
          cnt_d   = '0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        for (int j = 0; j < BSMODS; j++) begin
          if (GW'(j) == grant_q) unused_d[j] = 1'b1;
        end
        served_d = served_inc;
        state_d  = (served_inc == num_q) ? S_DONE : S_ARB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      base_q   <= '0;
      num_q    <= '0;
      served_q <= '0;
      unused_q <= '0;
      data_q   <= '0;
      pend_q   <= 1'b0;
      pidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      num_q    <= num_d;
      served_q <= served_d;
      unused_q <= unused_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      pidx_q   <= pidx_d;
    end
  end

  always_comb begin
    REG_READY = '1;
    for (int j = 0; j < BSMODS; j++) begin
      if (filling && (grant_q == GW'(j))) REG_READY[j] = 1'b0;
    end
  end

  assign mem_rd_en     = (state_q == S_FETCH);
  assign mem_addr      = mem_rd_en ? (base_q + served_q * AW'(WORDS) + AW'(cnt_q)) : '0;
  assign BS_DATA       = data_q;
  assign hasUnusedData = unused_q;
  assign OutOfData     = (state_q == S_DONE);
  assign recordsServed = served_q;

endmodule
